wb_write_buffer: RTL and testbench
==================================

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered writeback entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset; it is synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  meaning the pipeline offers a writeback.
REQ-005 SHALL have port in_ready  output  1  meaning the buffer can accept a writeback this cycle.
REQ-006 SHALL have port in_addr  input  5  meaning the destination register index.
REQ-007 SHALL have port in_data  input  32  meaning the writeback value.
REQ-008 SHALL have port drain_hold  input  1  meaning that, while high, the buffer does not drain to the register file.
REQ-009 SHALL have port WriteEnable  output  1  meaning the register-file write strobe.
REQ-010 SHALL have port Address3  output  5  meaning the register-file write index.
REQ-011 SHALL have port WriteData  output  32  meaning the register-file write value.
REQ-012 SHALL have port Address1  input  5  meaning bypass lookup index 1, shared with the register-file read port 1.
REQ-013 SHALL have port Address2  input  5  meaning bypass lookup index 2, shared with the register-file read port 2.
REQ-014 SHALL have ports Bypass1Hit and Bypass2Hit  output  1 each  meaning that a pending entry matches Address1 or Address2 respectively.
REQ-015 SHALL have ports Bypass1Data and Bypass2Data  output  32 each  meaning the bypass value for lookup 1 or lookup 2.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of entries held.

Function
REQ-017 SHALL implement a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-018 SHALL drive in_ready = (count != DEPTH); a full buffer does not accept an entry even when it is popping in the same cycle.
REQ-019 SHALL, on in_valid & in_ready with in_addr != 0, enqueue {in_addr, in_data} at the clock edge.
REQ-020 SHALL, on in_valid & in_ready with in_addr == 0, accept the handshake and discard the data, leaving count unchanged.
REQ-021 SHALL, when count > 0 and drain_hold = 0, present the head entry combinationally: WriteEnable = 1, Address3 = head address, WriteData = head data.
REQ-022 SHALL pop the head entry at the clock edge ending every cycle in which WriteEnable = 1.
REQ-023 SHALL drive WriteEnable = 0, Address3 = 0 and WriteData = 0 whenever no entry is being presented.
REQ-024 SHALL have a minimum latency of one cycle, with no input-to-output pass-through: an entry enqueued at edge N is presented in the cycle after edge N and written at edge N+1.
REQ-025 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-026 SHALL compute bypass combinationally: BypassXHit = 1 if any held entry, including the head being written this cycle, has an address equal to AddressX and AddressX != 0.
REQ-027 SHALL return the youngest matching entry on BypassXData when several entries match; BypassXData = 0 when there is no hit.
REQ-028 SHALL never report a bypass hit for index 0.
REQ-029 SHALL keep count in the range 0..DEPTH at all times; overflow and underflow are impossible by construction.

Reset
REQ-030 SHALL, when rst = 0 at a clock edge, clear count and both pointers to 0 and discard all held entries.
REQ-031 SHALL, during and after reset, drive WriteEnable = 0, Address3 = 0, WriteData = 0, in_ready = 1, both bypass hits = 0 and both bypass data outputs = 0.
REQ-032 SHALL ignore any in_valid handshake in a cycle in which rst = 0; a reset asserted mid-drain discards the pending write.

Configuration
REQ-033 SHALL compile the bypass comparators and muxes only when macro WB_BYPASS_EN is defined.
REQ-034 SHALL, without WB_BYPASS_EN, tie Bypass1Hit, Bypass2Hit, Bypass1Data and Bypass2Data to 0 while keeping all FIFO behaviour identical.

Verification
REQ-035 SHALL pass this scenario: from reset, push {x5, 0x11111111} -> the next cycle shows WriteEnable = 1, Address3 = 5, WriteData = 0x11111111, then count returns to 0.
REQ-036 SHALL pass this scenario: hold drain_hold = 1 and push 4 entries -> count = 4 and in_ready = 0; a fifth push is not accepted; release drain_hold -> 4 writes drain in order over 4 cycles.
REQ-037 SHALL pass this scenario: with drain_hold = 1, push {x7, 0xA}, then {x7, 0xB}, and set Address1 = 7 -> Bypass1Hit = 1 and Bypass1Data = 0xB; Address2 = 0 -> Bypass2Hit = 0.
REQ-038 SHALL pass this scenario: push {x0, 0xFFFFFFFF} -> in_ready handshake completes, count stays 0 and no write is presented.
REQ-039 SHALL pass this scenario: with 3 entries held, assert rst = 0 for one cycle -> count = 0 and WriteEnable = 0 at the next cycle, and no held entry is ever written.
REQ-040 SHALL pass this scenario: with pointers near wrap (DEPTH = 4, 6 cumulative pushes) and a push and pop in the same cycle -> count is unchanged and data order is preserved.

Source files
------------

// File: rtl/wb_write_buffer.sv
// wb_write_buffer: circular FIFO that holds register-file writebacks and
// drains them one per cycle into the register-file write port, with an
// optional bypass lookup so readers see values still sitting in the buffer.
//
// Optional feature macro: WB_BYPASS_EN (bypass comparators and muxes). When
// it is undefined, the bypass outputs are tied to zero and the FIFO behaves
// identically.
//
// Ports:
//   clk                       clock, all state updates on its rising edge
//   rst                       synchronous active-low reset
//   in_valid / in_ready       writeback handshake from the pipeline
//   in_addr / in_data         destination index / value (index 0 is discarded)
//   drain_hold                while high, the head entry is not written
//   WriteEnable               register-file write strobe (head presented)
//   Address3 / WriteData      register-file write index / value
//   Address1 / Address2       bypass lookup indices (shared with read ports)
//   Bypass1Hit / Bypass2Hit   a held entry matches the lookup index
//   Bypass1Data / Bypass2Data youngest matching value, 0 on miss
//   count                     number of entries held (0..DEPTH)
module wb_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [31:0]                in_data,
  input  logic                       drain_hold,
  output logic                       WriteEnable,
  output logic [4:0]                 Address3,
  output logic [31:0]                WriteData,
  input  logic [4:0]                 Address1,
  input  logic [4:0]                 Address2,
  output logic                       Bypass1Hit,
  output logic                       Bypass2Hit,
  output logic [31:0]                Bypass1Data,
  output logic [31:0]                Bypass2Data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          push;
  logic          pop;

  // Handshake, enqueue/dequeue decisions and head presentation. Everything is
  // gated by rst so nothing is accepted or written during a reset cycle.
  always_comb begin
    in_ready    = 1'b1;
    accept      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    WriteEnable = 1'b0;
    Address3    = '0;
    WriteData   = '0;
    if (rst) begin
      in_ready = (cnt != CW'(DEPTH));
      accept   = in_valid && in_ready;
      push     = accept && (in_addr != '0);
      pop      = (cnt != '0) && !drain_hold;
    end
    if (pop) begin
      WriteEnable = 1'b1;
      Address3    = mem[rd_ptr].addr;
      WriteData   = mem[rd_ptr].data;
    end
  end

  // Entry storage; contents need no reset since occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: in_addr, data: in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match (youngest) wins; the head
  // being written this cycle is still a held entry and may hit.
  always_comb begin
    idx         = '0;
    Bypass1Hit  = 1'b0;
    Bypass2Hit  = 1'b0;
    Bypass1Data = '0;
    Bypass2Data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt) begin
        if ((Address1 != '0) && (mem[idx].addr == Address1)) begin
          Bypass1Hit  = 1'b1;
          Bypass1Data = mem[idx].data;
        end
        if ((Address2 != '0) && (mem[idx].addr == Address2)) begin
          Bypass2Hit  = 1'b1;
          Bypass2Data = mem[idx].data;
        end
      end
    end
    if (!rst) begin
      Bypass1Hit  = 1'b0;
      Bypass2Hit  = 1'b0;
      Bypass1Data = '0;
      Bypass2Data = '0;
    end
  end
`else
  assign Bypass1Hit  = 1'b0;
  assign Bypass2Hit  = 1'b0;
  assign Bypass1Data = '0;
  assign Bypass2Data = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed testbench for wb_write_buffer (DEPTH = 4).
module tb_wb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_hold;
  logic        WriteEnable;
  logic [4:0]  Address3;
  logic [31:0] WriteData;
  logic [4:0]  Address1;
  logic [4:0]  Address2;
  logic        Bypass1Hit;
  logic        Bypass2Hit;
  logic [31:0] Bypass1Data;
  logic [31:0] Bypass2Data;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  wb_write_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .drain_hold (drain_hold),
    .WriteEnable(WriteEnable),
    .Address3   (Address3),
    .WriteData  (WriteData),
    .Address1   (Address1),
    .Address2   (Address2),
    .Bypass1Hit (Bypass1Hit),
    .Bypass2Hit (Bypass2Hit),
    .Bypass1Data(Bypass1Data),
    .Bypass2Data(Bypass2Data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_hold = 1'b0; Address1 = '0; Address2 = '0;

    // Reset state
    cyc(); cyc();
    Address1 = 5'd5;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(WriteEnable), 32'd0);
    check("rst_a3", 32'(Address3), 32'd0);
    check("rst_wd", WriteData, 32'd0);
    check("rst_hit1", 32'(Bypass1Hit), 32'd0);
    check("rst_bd1", Bypass1Data, 32'd0);
    Address1 = '0;

    // Single push, presented one cycle later, then drained
    cyc();
    rst = 1'b1;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h1111_1111;
    #1;
    check("s1_ready", 32'(in_ready), 32'd1);
    check("s1_no_passthru", 32'(WriteEnable), 32'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    check("s1_we", 32'(WriteEnable), 32'd1);
    check("s1_a3", 32'(Address3), 32'd5);
    check("s1_wd", WriteData, 32'h1111_1111);
    check("s1_count", 32'(count), 32'd1);
    cyc();
    check("s1_count_end", 32'(count), 32'd0);
    check("s1_we_end", 32'(WriteEnable), 32'd0);

    // Fill under drain_hold, reject fifth push, drain in order
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'hA0 + 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    check("s2_count_full", 32'(count), 32'd4);
    check("s2_not_ready", 32'(in_ready), 32'd0);
    check("s2_held", 32'(WriteEnable), 32'd0);
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
    cyc();
    in_valid = 1'b0;
    check("s2_fifth_rejected", 32'(count), 32'd4);
    drain_hold = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check("s2_drain_we", 32'(WriteEnable), 32'd1);
      check("s2_drain_a3", 32'(Address3), 32'(i));
      check("s2_drain_wd", WriteData, 32'hA0 + 32'(i));
      cyc();
    end
    check("s2_empty", 32'(count), 32'd0);
    check("s2_we_off", 32'(WriteEnable), 32'd0);

    // Bypass returns the youngest matching entry; index 0 never hits
    drain_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
    cyc();
    in_data = 32'hB;
    cyc();
    in_valid = 1'b0;
    Address1 = 5'd7; Address2 = 5'd0;
    #1;
    check("s3_count", 32'(count), 32'd2);
    check("s3_hit1", 32'(Bypass1Hit), 32'(BYP));
    check("s3_data1", Bypass1Data, BYP ? 32'hB : 32'h0);
    check("s3_hit2_zero", 32'(Bypass2Hit), 32'd0);
    check("s3_data2_zero", Bypass2Data, 32'd0);
    Address2 = 5'd3;
    #1;
    check("s3_miss2", 32'(Bypass2Hit), 32'd0);
    drain_hold = 1'b0;
    #1;
    check("s3_d0_a3", 32'(Address3), 32'd7);
    check("s3_d0_wd", WriteData, 32'hA);
    check("s3_head_hit", Bypass1Data, BYP ? 32'hB : 32'h0);
    cyc();
    check("s3_d1_wd", WriteData, 32'hB);
    check("s3_last_hit", 32'(Bypass1Hit), 32'(BYP));
    cyc();
    check("s3_empty", 32'(count), 32'd0);
    check("s3_no_hit_empty", 32'(Bypass1Hit), 32'd0);
    Address1 = '0; Address2 = '0;

    // Simultaneous push and pop across pointer wrap (rd/wr at 3 here)
    drain_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h33;
    cyc();
    drain_hold = 1'b0;
    in_addr = 5'd4; in_data = 32'h44;
    #1;
    check("s4_head_a3", 32'(Address3), 32'd3);
    check("s4_head_wd", WriteData, 32'h33);
    cyc();
    in_valid = 1'b0;
    #1;
    check("s4_count_same", 32'(count), 32'd1);
    check("s4_next_a3", 32'(Address3), 32'd4);
    check("s4_next_wd", WriteData, 32'h44);
    cyc();
    check("s4_empty", 32'(count), 32'd0);

    // Index-0 writeback is accepted and discarded
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    check("s5_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("s5_count", 32'(count), 32'd0);
    check("s5_no_we", 32'(WriteEnable), 32'd0);
    check("s5_a3", 32'(Address3), 32'd0);

    // Reset with three entries held, asserted while draining
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'(i + 1);
      cyc();
    end
    in_valid = 1'b0;
    Address1 = 5'd11;
    #1;
    check("s6_count3", 32'(count), 32'd3);
    check("s6_hit_pre", Bypass1Data, BYP ? 32'd2 : 32'd0);
    drain_hold = 1'b0;
    rst = 1'b0;
    in_valid = 1'b1; in_addr = 5'd20; in_data = 32'h5;
    #1;
    check("s6_we_in_rst", 32'(WriteEnable), 32'd0);
    check("s6_hit_in_rst", 32'(Bypass1Hit), 32'd0);
    check("s6_ready_in_rst", 32'(in_ready), 32'd1);
    cyc();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("s6_count0", 32'(count), 32'd0);
    check("s6_we0", 32'(WriteEnable), 32'd0);
    check("s6_hit_after", 32'(Bypass1Hit), 32'd0);
    cyc();
    check("s6_still_empty", 32'(count), 32'd0);
    check("s6_never_written", 32'(WriteEnable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
